// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART frame constants and receiver state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // start + data + parity + stop, identical framing on both directions
    localparam int FRAME_BITS         = 11;
    localparam bit PARITY_EVEN        = 1'b1;
    localparam int DEFAULT_OVERSAMPLE = 16;
    localparam int DEFAULT_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } uart_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sync2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_sync2
// Description : Two-flop synchronizer for a single asynchronous input.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync2 #(
    parameter bit RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : uart_sync2
`default_nettype wire

// File: rtl/uart_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_receiver
// Description : Oversampled UART receive stage, start/8N data/even parity/stop.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int DATA_BITS  = DEFAULT_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inrx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int c_tick_w = $clog2(OVERSAMPLE);
    localparam int c_bit_w  = $clog2(DATA_BITS + 1);
    localparam logic [c_tick_w-1:0] c_tick_half = c_tick_w'(OVERSAMPLE / 2 - 1);
    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(OVERSAMPLE - 1);
    localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(DATA_BITS - 1);

    uart_state_t            r_state;
    uart_state_t            w_state_nxt;
    logic [c_tick_w-1:0]    r_tick_cnt;
    logic [c_tick_w-1:0]    w_tick_nxt;
    logic [c_bit_w-1:0]     r_bit_cnt;
    logic [c_bit_w-1:0]     w_bit_nxt;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   w_shift_nxt;
    logic                   r_par_bit;
    logic                   w_par_nxt;
    logic                   w_frame_done;
    logic                   w_tick_wrap;
    logic                   w_rx_s;

    logic [DATA_BITS-1:0]   r_data_out;
    logic                   r_rx_valid;
    logic                   r_parity_err;
    logic                   r_frame_err;

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk (clk),
        .rst (reset),
        .i_d (rx),
        .o_q (w_rx_s)
    );

    // Explicit wrap keeps bit timing exact for non-power-of-two oversampling
    assign w_tick_wrap = (r_tick_cnt == c_tick_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_tick_nxt   = r_tick_cnt;
        w_bit_nxt    = r_bit_cnt;
        w_shift_nxt  = r_shift;
        w_par_nxt    = r_par_bit;
        w_frame_done = 1'b0;

        if (inrx) begin
            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        w_state_nxt = START;
                        w_tick_nxt  = '0;
                    end
                end
                START: begin
                    if (r_tick_cnt == c_tick_half) begin
                        w_tick_nxt = '0;
                        if (!w_rx_s) begin
                            w_bit_nxt   = '0;
                            w_state_nxt = DATA;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
                DATA: begin
                    w_tick_nxt = w_tick_wrap ? '0 : r_tick_cnt + 1'b1;
                    if (w_tick_wrap) begin
                        // LSB arrives first, so filling from the MSB side leaves it at bit 0
                        w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
                        w_bit_nxt   = r_bit_cnt + 1'b1;
                        if (r_bit_cnt == c_bit_last) begin
                            w_state_nxt = PARITY;
                        end
                    end
                end
                PARITY: begin
                    w_tick_nxt = w_tick_wrap ? '0 : r_tick_cnt + 1'b1;
                    if (w_tick_wrap) begin
                        w_par_nxt   = w_rx_s;
                        w_state_nxt = STOP;
                    end
                end
                STOP: begin
                    w_tick_nxt = w_tick_wrap ? '0 : r_tick_cnt + 1'b1;
                    if (w_tick_wrap) begin
                        w_frame_done = 1'b1;
                        w_state_nxt  = w_rx_s ? IDLE : WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (w_rx_s) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par_bit    <= 1'b0;
            r_data_out   <= '0;
            r_rx_valid   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_par_bit  <= w_par_nxt;
            r_rx_valid <= w_frame_done;
            if (w_frame_done) begin
                r_data_out   <= r_shift;
                r_parity_err <= ^r_shift ^ r_par_bit ^ ~PARITY_EVEN;
                r_frame_err  <= ~w_rx_s;
            end
        end
    end

    assign data_out   = r_data_out;
    assign rx_valid   = r_rx_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign busy       = (r_state != IDLE);

endmodule : uart_receiver
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_receiver
// Description : Directed self-checking bench for uart_receiver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       inrx  = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int n_total  = 0;
    int n_bad    = 0;
    int tick_div = 0;
    int n_valid  = 0;
    int base     = 0;

    logic [7:0] cap_data [0:15];
    logic       cap_perr [0:15];
    logic       cap_ferr [0:15];

    uart_receiver #(
        .OVERSAMPLE (16),
        .DATA_BITS  (8)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .inrx       (inrx),
        .rx         (rx),
        .data_out   (data_out),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Oversample tick: one clk-wide pulse every 4 clocks
    always @(posedge clk) begin
        tick_div <= (tick_div == 3) ? 0 : tick_div + 1;
        inrx     <= (tick_div == 3);
    end

    // Each high cycle counts, so a stretched strobe shows up as an extra pulse
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            if (n_valid < 16) begin
                cap_data[n_valid] = data_out;
                cap_perr[n_valid] = parity_err;
                cap_ferr[n_valid] = frame_err;
            end
            n_valid = n_valid + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (inrx !== 1'b1) @(posedge clk);
        end
    endtask

    task automatic drive_bit(input logic v);
        #1 rx = v;
        wait_ticks(16);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(par);
        drive_bit(stop);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_data", data_out, 8'h00);
        check_eq("rst_valid", rx_valid, 1'b0);
        check_eq("rst_perr", parity_err, 1'b0);
        check_eq("rst_ferr", frame_err, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        reset = 1'b0;
        wait_ticks(20);

        // Good frame
        base = n_valid;
        send_frame(8'hAA, 1'b0, 1'b1);
        wait_ticks(4);
        #1;
        check_eq("good_count", n_valid - base, 1);
        check_eq("good_data", data_out, 8'hAA);
        check_eq("good_cap", cap_data[base], 8'hAA);
        check_eq("good_perr", parity_err, 1'b0);
        check_eq("good_ferr", frame_err, 1'b0);
        check_eq("good_busy", busy, 1'b0);

        // Parity error, then clear
        base = n_valid;
        send_frame(8'h01, 1'b0, 1'b1);
        wait_ticks(4);
        #1;
        check_eq("perr_count", n_valid - base, 1);
        check_eq("perr_data", data_out, 8'h01);
        check_eq("perr_flag", parity_err, 1'b1);
        check_eq("perr_cap", cap_perr[base], 1'b1);
        base = n_valid;
        send_frame(8'h55, 1'b0, 1'b1);
        wait_ticks(4);
        #1;
        check_eq("pclr_data", data_out, 8'h55);
        check_eq("pclr_flag", parity_err, 1'b0);

        // Framing error followed by a break
        base = n_valid;
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_ticks(48);
        #1;
        check_eq("brk_count", n_valid - base, 1);
        check_eq("brk_data", data_out, 8'h3C);
        check_eq("brk_ferr", frame_err, 1'b1);
        check_eq("brk_cap_ferr", cap_ferr[base], 1'b1);
        check_eq("brk_perr", parity_err, 1'b0);
        check_eq("brk_busy_hold", busy, 1'b1);
        rx = 1'b1;
        wait_ticks(4);
        #1;
        check_eq("brk_busy_rel", busy, 1'b0);
        check_eq("brk_no_second", n_valid - base, 1);
        wait_ticks(20);

        // Glitch rejection
        base = n_valid;
        #1 rx = 1'b0;
        wait_ticks(4);
        #1;
        check_eq("glitch_busy", busy, 1'b1);
        rx = 1'b1;
        wait_ticks(8);
        #1;
        check_eq("glitch_idle", busy, 1'b0);
        check_eq("glitch_novalid", n_valid - base, 0);
        wait_ticks(20);

        // Back-to-back frames
        base = n_valid;
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        send_frame(8'hA5, 1'b0, 1'b1);
        wait_ticks(8);
        #1;
        check_eq("b2b_count", n_valid - base, 3);
        check_eq("b2b_d0", cap_data[base], 8'h00);
        check_eq("b2b_d1", cap_data[base + 1], 8'hFF);
        check_eq("b2b_d2", cap_data[base + 2], 8'hA5);
        check_eq("b2b_err", {cap_perr[base], cap_ferr[base], cap_perr[base + 1],
                             cap_ferr[base + 1], cap_perr[base + 2], cap_ferr[base + 2]}, 6'b0);

        // Reset in the middle of 0x5A
        base = n_valid;
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        #1;
        check_eq("mid_busy", busy, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("mid_rst_data", data_out, 8'h00);
        check_eq("mid_rst_busy", busy, 1'b0);
        check_eq("mid_rst_valid", rx_valid, 1'b0);
        check_eq("mid_rst_flags", {parity_err, frame_err}, 2'b00);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        wait_ticks(20);
        check_eq("mid_novalid", n_valid - base, 0);
        send_frame(8'h5A, 1'b0, 1'b1);
        wait_ticks(4);
        #1;
        check_eq("after_count", n_valid - base, 1);
        check_eq("after_data", data_out, 8'h5A);
        check_eq("after_flags", {parity_err, frame_err}, 2'b00);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_uart_receiver
`default_nettype wire
